// File: rtl/display_scan_ctrl.sv
// Two-digit seven-segment sequencer: serial binary-to-BCD conversion plus a shared-decoder digit scanner.
// Optional build macro: BLANK_LEADING_ZERO_EN blanks the tens position while tens_q is zero.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [4:0] in,
    output logic       upd,
    output logic [3:0] digit,
    output logic [1:0] digit_en
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t state;
    state_t state_nxt;

    logic [4:0]    rem;
    logic [1:0]    tcnt;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          xfer;
    logic          rem_ge10;
    logic [CW-1:0] cnt;
    logic          sel;
    logic          wrap;
    logic [1:0]    tens_en;

    assign xfer     = in_val && in_rdy;
    assign rem_ge10 = (rem >= 5'd10);
    assign wrap     = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = CONV;
            CONV:    if (!rem_ge10) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = (state == IDLE);
    end

    // tens_q/ones_q move together on the commit edge, so the display never shows a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            tcnt   <= '0;
            tens_q <= '0;
            ones_q <= '0;
            upd    <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rem  <= in;
                        tcnt <= '0;
                    end
                end
                CONV: begin
                    if (rem_ge10) begin
                        rem  <= rem - 5'd10;
                        tcnt <= tcnt + 2'd1;
                    end else begin
                        tens_q <= {2'b00, tcnt};
                        ones_q <= rem[3:0];
                        upd    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BLANK_LEADING_ZERO_EN
    assign tens_en = (tens_q == 4'd0) ? 2'b00 : 2'b10;
`else
    assign tens_en = 2'b10;
`endif

    // Scanner is free-running; digit/digit_en are loaded only when sel flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sel      <= 1'b0;
            digit    <= 4'd0;
            digit_en <= 2'b01;
        end else if (wrap) begin
            cnt <= '0;
            sel <= ~sel;
            if (!sel) begin
                digit    <= tens_q;
                digit_en <= tens_en;
            end else begin
                digit    <= ones_q;
                digit_en <= 2'b01;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
